// File: rtl/slot_reels.sv
// Four-reel slot machine digit generator.
// A spin request starts all four reels rolling, one digit per tick. The
// reels then stop one after another. Each reel's final digit is taken from
// a free-running 16-bit LFSR at that reel's stop tick. When the last reel
// stops, the block raises a one-cycle result_valid and reports whether all
// four digits are equal.
module slot_reels #(
  parameter int          TICK_DIV  = 4,
  parameter int          STOP_BASE = 8,
  parameter int          STOP_STEP = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spin_req,
  output logic [3:0] randNum1,
  output logic [3:0] randNum2,
  output logic [3:0] randNum3,
  output logic [3:0] randNum4,
  output logic       busy,
  output logic       result_valid,
  output logic       match
);

  localparam int STOP_LAST = STOP_BASE + 3 * STOP_STEP;
  localparam int PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TW        = $clog2(STOP_LAST + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    SPIN,
    DONE
  } state_t;

  state_t        state;
  logic [15:0]   lfsr;
  logic [PW-1:0] prescaler;
  logic [TW-1:0] tick_cnt;
  logic [TW-1:0] tick_nxt;
  logic [3:0]    rolling;
  logic [3:0]    stop_hit;
  logic [3:0]    digit     [4];
  logic [3:0]    digit_nxt [4];
  logic          all_eq;

  // Tick index (1-based) at which reel k (0-based) comes to rest.
  function automatic logic [TW-1:0] stop_at(input int k);
    return TW'(STOP_BASE + k * STOP_STEP);
  endfunction

  // Digits each reel would show after the current tick, and stop detection.
  always_comb begin
    // NOTE: every output of this block gets a value before any branch, so
    // no path leaves a signal unassigned and no latch is inferred.
    tick_nxt  = tick_cnt + TW'(1);
    stop_hit  = '0;
    digit_nxt = digit;
    for (int k = 0; k < 4; k++) begin
      stop_hit[k] = rolling[k] && (tick_nxt == stop_at(k));
      if (stop_hit[k]) begin
        // Fold the nibble into 0..9: values 10..15 map onto 0..5.
        digit_nxt[k] = (lfsr[4*k +: 4] < 4'd10) ? lfsr[4*k +: 4]
                                                : lfsr[4*k +: 4] - 4'd10;
      end else if (rolling[k]) begin
        digit_nxt[k] = (digit[k] == 4'd9) ? 4'd0 : digit[k] + 4'd1;
      end
    end
    all_eq = (digit_nxt[0] == digit_nxt[1]) &&
             (digit_nxt[1] == digit_nxt[2]) &&
             (digit_nxt[2] == digit_nxt[3]);
  end

  // Spin sequencer, reel registers and free-running LFSR.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples the pre-edge values, whatever the statement order.
    if (!rst) begin
      state        <= IDLE;
      lfsr         <= LFSR_SEED;
      prescaler    <= '0;
      tick_cnt     <= '0;
      rolling      <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      match        <= 1'b0;
      // NOTE: the reel array is only four small registers feeding outputs
      // that must read 0 after reset, so it is reset like any other flop.
      for (int k = 0; k < 4; k++) digit[k] <= 4'd0;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      case (state)
        IDLE: begin
          result_valid <= 1'b0;
          if (spin_req) begin
            state     <= SPIN;
            prescaler <= '0;
            tick_cnt  <= '0;
            match     <= 1'b0;
            rolling   <= 4'hF;
            busy      <= 1'b1;
          end
        end
        SPIN: begin
          if (prescaler == PRE_LAST) begin
            prescaler <= '0;
            tick_cnt  <= tick_nxt;
            digit     <= digit_nxt;
            rolling   <= rolling & ~stop_hit;
            if (stop_hit[3]) begin
              state        <= DONE;
              busy         <= 1'b0;
              result_valid <= 1'b1;
              match        <= all_eq;
            end
          end else begin
            prescaler <= prescaler + PW'(1);
          end
        end
        DONE: begin
          result_valid <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign randNum1 = digit[0];
  assign randNum2 = digit[1];
  assign randNum3 = digit[2];
  assign randNum4 = digit[3];

endmodule

// File: tb/tb_slot_reels.sv
// Self-checking bench for slot_reels. Two instances: one at default
// parameters and one with a faster, shorter schedule and another seed.
// Expected outputs come from a timeline model: after a spin accepted at
// edge E, the outputs m edges later follow from m, the tick period, the
// stop ticks and the LFSR state at each stop edge.
module tb_slot_reels;

  localparam int          A_TD = 4, A_SB = 8, A_SS = 4;
  localparam logic [15:0] A_SEED = 16'hACE1;
  localparam int          B_TD = 2, B_SB = 3, B_SS = 2;
  localparam logic [15:0] B_SEED = 16'h1234;
  localparam int          SEQ_LEN = 61000;

  typedef struct packed {
    logic [15:0] digits;  // {reel4, reel3, reel2, reel1}
    logic        busy;
    logic        rv;
    logic        match;
  } out_t;

  typedef struct {
    int gap;
    int extra_at;
    int exp_busy;
    int exp_pulses;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       spin_a = 1'b0;
  logic       spin_b = 1'b0;
  logic [3:0] a1, a2, a3, a4, b1, b2, b3, b4;
  logic       a_busy, a_rv, a_match, b_busy, b_rv, b_match;

  int          checks = 0;
  int          failures = 0;
  int          edges = 0;
  logic [15:0] prev       [2];
  logic        last_match [2];
  logic [15:0] seq        [SEQ_LEN];

  always #5 clk = ~clk;

  slot_reels u_a (
    .clk(clk), .rst(rst), .spin_req(spin_a),
    .randNum1(a1), .randNum2(a2), .randNum3(a3), .randNum4(a4),
    .busy(a_busy), .result_valid(a_rv), .match(a_match)
  );

  slot_reels #(
    .TICK_DIV(B_TD), .STOP_BASE(B_SB), .STOP_STEP(B_SS), .LFSR_SEED(B_SEED)
  ) u_b (
    .clk(clk), .rst(rst), .spin_req(spin_b),
    .randNum1(b1), .randNum2(b2), .randNum3(b3), .randNum4(b4),
    .busy(b_busy), .result_valid(b_rv), .match(b_match)
  );

  // ---------------- reference model ----------------
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [15:0] lfsr_at(input logic [15:0] seed, input int n);
    logic [15:0] s = seed;
    for (int i = 0; i < n; i++) s = lfsr_next(s);
    return s;
  endfunction

  function automatic logic [3:0] to_digit(input logic [3:0] n);
    return 4'(int'(n) % 10);
  endfunction

  function automatic logic all_eq(input logic [15:0] d);
    return (d[3:0] == d[7:4]) && (d[7:4] == d[11:8]) && (d[11:8] == d[15:12]);
  endfunction

  // Final digits for a spin accepted at edge e (edges counted from reset release).
  function automatic logic [15:0] finals(input logic [15:0] seed, input int e,
                                         input int td, input int sb, input int ss);
    logic [15:0] f = '0;
    logic [15:0] s;
    for (int k = 0; k < 4; k++) begin
      s = lfsr_at(seed, e + (sb + k * ss) * td);
      f[4*k +: 4] = to_digit(s[4*k +: 4]);
    end
    return f;
  endfunction

  // Outputs m edges after the accepting edge.
  function automatic out_t expect_at(input int m, input int td, input int sb,
                                     input int ss, input logic [15:0] pd,
                                     input logic [15:0] fin);
    out_t o;
    int   j    = m / td;
    int   last = (sb + 3 * ss) * td;
    for (int k = 0; k < 4; k++) begin
      if (j < sb + k * ss) o.digits[4*k +: 4] = 4'((int'(pd[4*k +: 4]) + j) % 10);
      else                 o.digits[4*k +: 4] = fin[4*k +: 4];
    end
    o.busy  = (m < last);
    o.rv    = (m == last);
    o.match = (m >= last) && all_eq(fin);
    return o;
  endfunction

  function automatic out_t idle_exp(input int s);
    out_t o;
    o.digits = prev[s];
    o.busy   = 1'b0;
    o.rv     = 1'b0;
    o.match  = last_match[s];
    return o;
  endfunction

  function automatic out_t observe(input int s);
    out_t o;
    if (s == 1) o = {b4, b3, b2, b1, b_busy, b_rv, b_match};
    else        o = {a4, a3, a2, a1, a_busy, a_rv, a_match};
    return o;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    edges++;
    @(negedge clk);
  endtask

  task automatic set_spin(input int s, input logic v);
    if (s == 1) spin_b = v;
    else        spin_a = v;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      for (int s = 0; s < 2; s++)
        check($sformatf("idle%0d", s), {13'b0, observe(s)}, {13'b0, idle_exp(s)});
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    for (int s = 0; s < 2; s++)
      check($sformatf("reset_now%0d", s), {13'b0, observe(s)}, 32'd0);
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++)
      check($sformatf("reset_hold%0d", s), {13'b0, observe(s)}, 32'd0);
    rst   = 1'b1;
    edges = 0;
    for (int s = 0; s < 2; s++) begin
      prev[s]       = '0;
      last_match[s] = 1'b0;
    end
  endtask

  // One spin on instance s, checked every cycle until a few cycles after DONE.
  // stop_at_m >= 0 asserts reset right after that edge instead of finishing.
  task automatic run_spin(input int s, input int extra_at, input int stop_at_m,
                          output int busy_cnt, output int pulses);
    int          td, sb, ss, e, last;
    logic [15:0] seed, fin;
    out_t        o;
    td   = (s == 1) ? B_TD : A_TD;
    sb   = (s == 1) ? B_SB : A_SB;
    ss   = (s == 1) ? B_SS : A_SS;
    seed = (s == 1) ? B_SEED : A_SEED;
    last = (sb + 3 * ss) * td;
    busy_cnt = 0;
    pulses   = 0;
    set_spin(s, 1'b1);
    step();
    e = edges - 1;
    set_spin(s, 1'b0);
    fin = finals(seed, e, td, sb, ss);
    for (int m = 0; m <= last + 3; m++) begin
      if (m > 0) begin
        set_spin(s, m == extra_at);
        step();
        set_spin(s, 1'b0);
      end
      o = observe(s);
      busy_cnt += int'(o.busy);
      pulses   += int'(o.rv);
      check($sformatf("spin%0d m=%0d", s, m), {13'b0, o},
            {13'b0, expect_at(m, td, sb, ss, prev[s], fin)});
      check($sformatf("other%0d m=%0d", 1 - s, m), {13'b0, observe(1 - s)},
            {13'b0, idle_exp(1 - s)});
      if (m == stop_at_m) begin
        #2;
        do_reset();
        return;
      end
    end
    prev[s]       = fin;
    last_match[s] = all_eq(fin);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vec_t vecs [5];
    int   bc, p, s, found, last;
    logic [15:0] d;

    vecs = '{'{0, -1, 80, 1}, '{3, 40, 80, 1}, '{1, 81, 80, 1},
             '{2, 1, 80, 1},  '{4, 80, 80, 1}};

    seq[0] = A_SEED;
    for (int i = 1; i < SEQ_LEN; i++) seq[i] = lfsr_next(seq[i-1]);
    for (int k = 0; k < 2; k++) begin
      prev[k]       = '0;
      last_match[k] = 1'b0;
    end

    // Power-on reset, then release: outputs stay at zero while idle.
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++)
      check($sformatf("por%0d", k), {13'b0, observe(k)}, 32'd0);
    rst   = 1'b1;
    edges = 0;
    idle_cycles(5);

    // Table of spins on the default instance, some with ignored extra requests.
    for (int i = 0; i < 5; i++) begin
      idle_cycles(vecs[i].gap);
      run_spin(0, vecs[i].extra_at, -1, bc, p);
      check($sformatf("busy_cycles v%0d", i), bc, vecs[i].exp_busy);
      check($sformatf("rv_pulses v%0d", i), p, vecs[i].exp_pulses);
    end

    // Alternate-parameter instance: reels stop at ticks 3,5,7,9 of 2 clocks.
    idle_cycles(2);
    run_spin(1, -1, -1, bc, p);
    check("b_busy_cycles", bc, 18);
    check("b_rv_pulses", p, 1);
    run_spin(1, 10, -1, bc, p);
    check("b_rv_pulses_extra", p, 1);

    // Randomized spins on either instance with one stray request mid-spin.
    repeat (8) begin
      s    = int'($urandom_range(0, 1));
      last = (s == 1) ? 18 : 80;
      idle_cycles(int'($urandom_range(0, 7)));
      run_spin(s, int'($urandom_range(1, last + 1)), -1, bc, p);
      check($sformatf("rand_pulses%0d", s), p, 1);
    end

    // Reset in the middle of a spin, then a clean spin from the seed.
    idle_cycles(2);
    run_spin(0, -1, 50, bc, p);
    idle_cycles(4);
    run_spin(0, -1, -1, bc, p);
    check("post_reset_pulses", p, 1);

    // Match: pick a start edge after reset at which all four stop digits agree.
    #2;
    do_reset();
    found = -1;
    for (int e = 1; e < SEQ_LEN - 100 && found < 0; e++) begin
      for (int k = 0; k < 4; k++)
        d[4*k +: 4] = to_digit(seq[e + (A_SB + k * A_SS) * A_TD][4*k +: 4]);
      if (all_eq(d)) found = e;
    end
    if (found < 0) begin
      checks++;
      failures++;
      $display("FAIL match_search: got no start edge, required one below %0d", SEQ_LEN);
    end else begin
      idle_cycles(found);
      run_spin(0, -1, -1, bc, p);
      check("match_after_spin", {31'b0, a_match}, 32'd1);
      idle_cycles(3);
      check("match_held", {31'b0, a_match}, 32'd1);
      run_spin(0, -1, -1, bc, p);
      check("match_next_spin", {31'b0, a_match}, {31'b0, last_match[0]});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule
